// File: rtl/core_run_ctrl.sv
// Run controller for a test core: holds the core in reset, runs it until a tohost
// write or the watchdog fires, and keeps registered result flags and statistics.
module core_run_ctrl #(
   parameter int unsigned      WIDTH           = 32,
   parameter int unsigned      RST_HOLD_CYCLES = 1,
   parameter int unsigned      TIMEOUT_CYCLES  = 300,
   parameter logic [WIDTH-1:0] TOHOST_ADDR     = WIDTH'(32'h0000_1000)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             instr_retire,
   input  logic             dmem_we,
   input  logic [WIDTH-1:0] dmem_addr,
   input  logic [WIDTH-1:0] dmem_wdata,
   output logic             core_rst,
   output logic             running,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic             timeout,
   output logic [WIDTH-1:0] cycle_count,
   output logic [WIDTH-1:0] instret_count,
   output logic [WIDTH-1:0] exit_code
);

   localparam int unsigned      HW        = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
   localparam logic [HW-1:0]    HOLD_LAST = HW'(RST_HOLD_CYCLES - 32'd1);
   localparam logic             TMO_EN    = (TIMEOUT_CYCLES != 32'd0);
   localparam logic [WIDTH-1:0] TO_LAST   = WIDTH'(TIMEOUT_CYCLES - 32'd1);
   localparam logic [WIDTH-1:0] ONE       = WIDTH'(1'b1);
   localparam logic [WIDTH-1:0] MAXV      = {WIDTH{1'b1}};

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      RESET_HOLD = 2'd1,
      RUN        = 2'd2,
      DONE       = 2'd3
   } state_t;

   state_t           state_r, next_s;
   logic [HW-1:0]    hold_r;
   logic             core_rst_r, running_r, done_r, pass_r, fail_r, timeout_r;
   logic [WIDTH-1:0] cycle_count_r, instret_count_r, exit_code_r;
   logic             tohost_s, tmo_s, enter_hold_s;

   // A tohost write wins over a coincident watchdog expiry
   assign tohost_s     = (state_r == RUN) && dmem_we && (dmem_addr == TOHOST_ADDR);
   assign tmo_s        = TMO_EN && (state_r == RUN) && !tohost_s && (cycle_count_r == TO_LAST);
   assign enter_hold_s = (next_s == RESET_HOLD) && (state_r != RESET_HOLD);

   // Next-state decode
   always_comb begin
      next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) next_s = RESET_HOLD;
            else       next_s = IDLE;
         end
         RESET_HOLD: begin
            if (hold_r == HOLD_LAST) next_s = RUN;
            else                     next_s = RESET_HOLD;
         end
         RUN: begin
            if (tohost_s || tmo_s) next_s = DONE;
            else                   next_s = RUN;
         end
         DONE: begin
            if (start) next_s = RESET_HOLD;
            else       next_s = DONE;
         end
         default: next_s = IDLE;
      endcase
   end

   // State, hold counter, decoded outputs and run statistics
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r         <= IDLE;
         hold_r          <= {HW{1'b0}};
         core_rst_r      <= 1'b1;
         running_r       <= 1'b0;
         done_r          <= 1'b0;
         pass_r          <= 1'b0;
         fail_r          <= 1'b0;
         timeout_r       <= 1'b0;
         cycle_count_r   <= {WIDTH{1'b0}};
         instret_count_r <= {WIDTH{1'b0}};
         exit_code_r     <= {WIDTH{1'b0}};
      end else begin
         state_r    <= next_s;
         core_rst_r <= (next_s != RUN);
         running_r  <= (next_s == RUN);
         done_r     <= (next_s == DONE);
         hold_r     <= ((state_r == RESET_HOLD) && (next_s == RESET_HOLD)) ?
                       hold_r + HW'(1'b1) : {HW{1'b0}};
         if (enter_hold_s) begin
            pass_r          <= 1'b0;
            fail_r          <= 1'b0;
            timeout_r       <= 1'b0;
            cycle_count_r   <= {WIDTH{1'b0}};
            instret_count_r <= {WIDTH{1'b0}};
            exit_code_r     <= {WIDTH{1'b0}};
         end else if (state_r == RUN) begin
            if (cycle_count_r != MAXV)
               cycle_count_r <= cycle_count_r + ONE;
            if (instr_retire && (instret_count_r != MAXV))
               instret_count_r <= instret_count_r + ONE;
            if (tohost_s) begin
               exit_code_r <= dmem_wdata;
               pass_r      <= (dmem_wdata == ONE);
               fail_r      <= (dmem_wdata != ONE);
            end else if (tmo_s) begin
               timeout_r <= 1'b1;
               fail_r    <= 1'b1;
            end
         end
      end
   end

   assign core_rst      = core_rst_r;
   assign running       = running_r;
   assign done          = done_r;
   assign pass          = pass_r;
   assign fail          = fail_r;
   assign timeout       = timeout_r;
   assign cycle_count   = cycle_count_r;
   assign instret_count = instret_count_r;
   assign exit_code     = exit_code_r;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Randomized self-checking bench for core_run_ctrl; expected run results are derived
// per run from the chosen tohost cycle, write data and retire pulses.
module tb_core_run_ctrl;

   localparam int          TMO    = 300;
   localparam logic [31:0] TOHOST = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst, start, instr_retire, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        core_rst, running, done, pass, fail, timeout;
   logic [31:0] cycle_count, instret_count, exit_code;

   int checks   = 0;
   int failures = 0;

   core_run_ctrl #(.WIDTH(32), .RST_HOLD_CYCLES(3), .TIMEOUT_CYCLES(TMO), .TOHOST_ADDR(TOHOST)) dut (
      .clk(clk), .rst(rst), .start(start), .instr_retire(instr_retire),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .core_rst(core_rst), .running(running), .done(done), .pass(pass), .fail(fail),
      .timeout(timeout), .cycle_count(cycle_count), .instret_count(instret_count),
      .exit_code(exit_code)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      start = 1'b0; instr_retire = 1'b0; dmem_we = 1'b0; dmem_addr = 32'h0; dmem_wdata = 32'h0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      step(); step();
      checks++; if (core_rst !== 1'b1) begin failures++; $display("FAIL reset_core_rst got=%b exp=1", core_rst); end
      checks++; if ({running, done, pass, fail, timeout} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {running, done, pass, fail, timeout}); end
      checks++; if ({cycle_count, instret_count, exit_code} !== 96'h0) begin failures++; $display("FAIL reset_stats got=%h/%h/%h exp=0", cycle_count, instret_count, exit_code); end
      rst = 1'b0;
      step();
      checks++; if ({core_rst, running} !== 2'b10) begin failures++; $display("FAIL idle_no_start got=%b exp=10", {core_rst, running}); end
   endtask

   // Starts a run from IDLE/DONE, checks results cleared, waits (bounded) for RUN
   task automatic begin_run();
      int n;
      start = 1'b1;
      step();
      start = 1'b0;
      checks++; if ({pass, fail, timeout, done} !== 4'b0) begin failures++; $display("FAIL start_clear_flags got=%b exp=0000", {pass, fail, timeout, done}); end
      checks++; if ({cycle_count, instret_count, exit_code} !== 96'h0) begin failures++; $display("FAIL start_clear_stats got=%h/%h/%h exp=0", cycle_count, instret_count, exit_code); end
      n = 0;
      while (!running && n < 10) begin step(); n++; end
      checks++; if (running !== 1'b1) begin failures++; $display("FAIL run_entry got=%b exp=1", running); end
   endtask

   // Drives RUN cycles from index first_i; term_at is the tohost cycle (-1 or >=TMO: none)
   task automatic run_body(input int first_i, input int inst0, input int term_at,
                           input logic [31:0] code, input int retire_first, input bit decoy);
      int          exp_term, exp_inst;
      bit          exp_to, r;
      logic [31:0] exp_exit, hold_cc, hold_ic, hold_ec;
      exp_to   = !(term_at >= 0 && term_at < TMO);
      exp_term = exp_to ? TMO - 1 : term_at;
      exp_exit = exp_to ? 32'h0 : code;
      exp_inst = inst0;
      for (int i = first_i; i <= exp_term; i++) begin
         r            = (retire_first >= 0) ? (i < retire_first) : 1'($urandom);
         instr_retire = r;
         start        = 1'($urandom);
         if (i == term_at) begin
            dmem_we = 1'b1; dmem_addr = TOHOST; dmem_wdata = code;
         end else if (decoy && i == term_at - 1) begin
            dmem_we = 1'b1; dmem_addr = TOHOST + 32'd4; dmem_wdata = 32'h1;
         end else begin
            dmem_we    = ($urandom % 4) == 0;
            dmem_addr  = $urandom;
            if (dmem_addr == TOHOST) dmem_addr = TOHOST ^ 32'h4;
            dmem_wdata = ($urandom % 2) ? 32'h1 : $urandom;
         end
         if (r) exp_inst++;
         step();
         if (i < exp_term) begin
            checks++; if ({running, done} !== 2'b10 || cycle_count !== 32'(i + 1)) begin
               failures++; $display("FAIL run_progress i=%0d got run=%b done=%b cc=%0d exp run=1 done=0 cc=%0d", i, running, done, cycle_count, i + 1);
            end
         end
      end
      idle_inputs();
      checks++; if ({done, running, core_rst} !== 3'b101) begin failures++; $display("FAIL done_state got=%b exp=101", {done, running, core_rst}); end
      checks++; if ({pass, fail, timeout} !== {!exp_to && code == 32'h1, exp_to || code != 32'h1, exp_to}) begin
         failures++; $display("FAIL result_flags got pft=%b%b%b exp=%b%b%b", pass, fail, timeout, !exp_to && code == 32'h1, exp_to || code != 32'h1, exp_to);
      end
      checks++; if (exit_code !== exp_exit) begin failures++; $display("FAIL exit_code got=%h exp=%h", exit_code, exp_exit); end
      checks++; if (cycle_count !== 32'(exp_term + 1)) begin failures++; $display("FAIL final_cycles got=%0d exp=%0d", cycle_count, exp_term + 1); end
      checks++; if (instret_count !== 32'(exp_inst)) begin failures++; $display("FAIL final_instret got=%0d exp=%0d", instret_count, exp_inst); end
      hold_cc = cycle_count; hold_ic = instret_count; hold_ec = exit_code;
      for (int k = 0; k < 3; k++) begin
         instr_retire = 1'b1; dmem_we = 1'b1; dmem_addr = TOHOST; dmem_wdata = 32'h5;
         step();
      end
      idle_inputs();
      checks++; if ({done, cycle_count, instret_count, exit_code} !== {1'b1, 32'(exp_term + 1), 32'(exp_inst), exp_exit} || hold_cc === 32'hx || hold_ic === 32'hx || hold_ec === 32'hx) begin
         failures++; $display("FAIL done_hold got done=%b cc=%0d ic=%0d ec=%h", done, cycle_count, instret_count, exit_code);
      end
   endtask

   task automatic test_hold_and_pass();
      int n;
      start = 1'b1; instr_retire = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while (core_rst && n < 10) begin n++; step(); end
      checks++; if (n !== 3) begin failures++; $display("FAIL hold_length got=%0d exp=3", n); end
      checks++; if ({running, cycle_count, instret_count} !== {1'b1, 32'h0, 32'h0}) begin
         failures++; $display("FAIL run_first got run=%b cc=%0d ic=%0d exp run=1 cc=0 ic=0", running, cycle_count, instret_count);
      end
      for (int i = 1; i <= 3; i++) begin
         step();
         checks++; if (cycle_count !== 32'(i)) begin failures++; $display("FAIL cycle_seq got=%0d exp=%0d", cycle_count, i); end
      end
      run_body(3, 3, 57, 32'h1, 40, 1'b0);
   endtask

   task automatic test_fail_code();
      begin_run();
      run_body(0, 0, 10 + int'($urandom_range(0, 150)), 32'h0000_0007, -1, 1'b1);
   endtask

   task automatic test_timeout();
      begin_run();
      run_body(0, 0, -1, 32'h0, -1, 1'b0);
      begin_run();
      run_body(0, 0, TMO - 1, 32'h1, -1, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 5; r++) begin
         begin_run();
         run_body(0, 0, int'($urandom_range(0, 349)), ($urandom % 2) ? 32'h1 : $urandom, -1, 1'($urandom));
      end
   endtask

   task automatic test_midrun_reset();
      begin_run();
      for (int i = 0; i < 20; i++) begin
         instr_retire = 1'($urandom);
         step();
      end
      #3;
      rst = 1'b1;
      #1;
      checks++; if ({core_rst, running, done, pass, fail, timeout} !== 6'b100000) begin
         failures++; $display("FAIL async_reset_flags got=%b exp=100000", {core_rst, running, done, pass, fail, timeout});
      end
      checks++; if ({cycle_count, instret_count, exit_code} !== 96'h0) begin failures++; $display("FAIL async_reset_stats got=%h/%h/%h exp=0", cycle_count, instret_count, exit_code); end
      idle_inputs();
      step();
      rst = 1'b0;
      step(); step();
      checks++; if ({core_rst, running, done} !== 3'b100) begin failures++; $display("FAIL post_reset_idle got=%b exp=100", {core_rst, running, done}); end
      begin_run();
      run_body(0, 0, int'($urandom_range(5, 100)), 32'h1, -1, 1'b0);
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      test_reset();
      test_hold_and_pass();
      test_fail_code();
      test_timeout();
      test_back_to_back();
      test_midrun_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/core_run_ctrl.md
CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data/address/counter width.
REQ-002 The block SHALL have parameter RST_HOLD_CYCLES, default 1, giving the number of cycles core_rst is held after start (minimum 1).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 300, giving the run-cycle watchdog limit (0 = watchdog disabled).
REQ-004 The block SHALL have parameter TOHOST_ADDR, default 32'h0000_1000, giving the data-memory address whose write ends a run.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port start, input, 1 bit: request to begin a run; sampled in IDLE and DONE only.
REQ-008 The block SHALL have port instr_retire, input, 1 bit: the core retired one instruction this cycle.
REQ-009 The block SHALL have port dmem_we, input, 1 bit: core data-memory write enable.
REQ-010 The block SHALL have port dmem_addr, input, WIDTH bits: core data-memory address.
REQ-011 The block SHALL have port dmem_wdata, input, WIDTH bits: core data-memory write data.
REQ-012 The block SHALL have port core_rst, output, 1 bit: reset driven to the core.
REQ-013 The block SHALL have port running, output, 1 bit: high while in RUN.
REQ-014 The block SHALL have port done, output, 1 bit: high while in DONE.
REQ-015 The block SHALL have ports pass, fail and timeout, outputs, 1 bit each: run result flags.
REQ-016 The block SHALL have ports cycle_count, instret_count and exit_code, outputs, WIDTH bits each: run statistics.

Function
REQ-017 The FSM SHALL have states IDLE, RESET_HOLD, RUN and DONE, all registered.
REQ-018 In IDLE: core_rst=1; start=1 SHALL move to RESET_HOLD next cycle and load the hold counter with 0.
REQ-019 In RESET_HOLD: core_rst=1; the hold counter SHALL increment each cycle and, when it reaches RST_HOLD_CYCLES-1, the FSM SHALL move to RUN next cycle.
REQ-020 On entry to RESET_HOLD: cycle_count, instret_count, exit_code, pass, fail and timeout SHALL all clear to 0.
REQ-021 In RUN: core_rst=0 and running=1; cycle_count SHALL increment by 1 per cycle, saturating at 2^WIDTH-1.
REQ-022 In RUN: instret_count SHALL increment on each cycle with instr_retire=1, saturating at 2^WIDTH-1; instr_retire SHALL be ignored outside RUN.
REQ-023 A tohost write is a RUN cycle with dmem_we=1 and dmem_addr==TOHOST_ADDR; it SHALL latch exit_code=dmem_wdata and move the FSM to DONE next cycle.
REQ-024 On a tohost write with dmem_wdata==1, pass SHALL be set; with any other value, fail SHALL be set.
REQ-025 With TIMEOUT_CYCLES!=0: a RUN cycle with cycle_count==TIMEOUT_CYCLES-1 and no tohost write SHALL move the FSM to DONE with timeout=1, fail=1 and exit_code unchanged (0).
REQ-026 A tohost write and the timeout condition in the same cycle SHALL resolve as a tohost write; timeout SHALL stay 0.
REQ-027 Writes to any address other than TOHOST_ADDR SHALL have no effect.
REQ-028 In DONE: core_rst=1 and done=1; pass, fail, timeout, exit_code and both counters SHALL hold their values.
REQ-029 start=1 in DONE SHALL move the FSM to RESET_HOLD; start in RESET_HOLD or RUN SHALL be ignored.
REQ-030 Status outputs SHALL be registered (no combinational path from inputs); done, pass, fail and timeout SHALL become visible in the first DONE cycle.

Reset
REQ-031 rst=1 SHALL immediately, without waiting for a clock edge, force: state=IDLE, core_rst=1, running=0, done=0, pass=0, fail=0, timeout=0, cycle_count=0, instret_count=0, exit_code=0 and hold counter=0.
REQ-032 rst asserted during any state, including mid-run, SHALL abort the run with no retained result; operation SHALL resume only after rst=0 and a new start.

Verification
REQ-033 Scenario: RST_HOLD_CYCLES=3; after rst, pulse start -> core_rst=1 for exactly 3 cycles after start, then running=1 with cycle_count counting 1,2,3…
REQ-034 Scenario: In RUN, write 32'h1 to 32'h0000_1000 at cycle_count=57 with 40 retire pulses -> done=1, pass=1, fail=0, exit_code=1, cycle_count=58, instret_count=40.
REQ-035 Scenario: Write 32'h0000_0007 to TOHOST_ADDR -> fail=1, pass=0, exit_code=7; a preceding write to 32'h0000_1004 -> no effect.
REQ-036 Scenario: TIMEOUT_CYCLES=300, no tohost write -> DONE after 300 RUN cycles with timeout=1, fail=1, cycle_count=300; tohost write on cycle 300 -> pass=1, timeout=0.
REQ-037 Scenario: rst pulsed mid-RUN between clock edges -> all outputs reset immediately and core_rst=1; start in DONE -> results clear and a new run starts.
